// File: rtl/wb_bram_arbiter_pkg.sv
// wb_bram_arbiter_pkg: FSM state encoding and one-hot grant constants for the two-master WISHBONE arbiter
// Holds the shared arbiter types: arb_state_e (IDLE/GNT0/GNT1), GNT_* one-hot grant codes,
// and gnt_of() mapping a state to its grant vector {M1,M0}.
package wb_bram_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  function automatic logic [1:0] gnt_of(input arb_state_e s);
    return s == GNT0 ? GNT_M0 : s == GNT1 ? GNT_M1 : GNT_NONE;
  endfunction
endpackage

// File: rtl/wb_bram_arbiter_watchdog.sv
// wb_bram_arbiter_watchdog: counts consecutive unacknowledged strobe cycles and flags expiry
// Ports: CLK_I clock, RST_I sync active-high reset, CLR clear count (ack / grant release),
//        RUN strobe presented this cycle, EXPIRE high on the TIMEOUT-th unacknowledged strobe cycle.
module wb_bram_arbiter_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic CLR,
  input  logic RUN,
  output logic EXPIRE
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // Expiry depends only on the registered count and the raw strobe, never on the slave ACK,
  // so the forced-low strobe cannot loop back through a combinational write acknowledge.
  assign EXPIRE = RUN & (cnt_q == LIMIT);
  always_comb cnt_d = (CLR | EXPIRE) ? '0 : (RUN & (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge CLK_I)
    if (RST_I) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: two-master WISHBONE arbiter, round-robin per locked CYC, onto one BRAM slave port
// Ports: CLK_I/RST_I clock and sync active-high reset; Mx_CYC_I/STB_I/WE_I/ADR_I/DAT_I master requests;
//        Mx_DAT_O/ACK_O/ERR_O master responses; S_STB_O/WE_O/ADR_O/DAT_O slave request;
//        S_DAT_I/S_ACK_I slave response; GNT_O one-hot current owner {M1,M0}.
module wb_bram_arbiter
  import wb_bram_arbiter_pkg::*;
#(
  parameter int AW      = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          M0_CYC_I,
  input  logic          M0_STB_I,
  input  logic          M0_WE_I,
  input  logic [AW-1:0] M0_ADR_I,
  input  logic [DW-1:0] M0_DAT_I,
  output logic [DW-1:0] M0_DAT_O,
  output logic          M0_ACK_O,
  output logic          M0_ERR_O,
  input  logic          M1_CYC_I,
  input  logic          M1_STB_I,
  input  logic          M1_WE_I,
  input  logic [AW-1:0] M1_ADR_I,
  input  logic [DW-1:0] M1_DAT_I,
  output logic [DW-1:0] M1_DAT_O,
  output logic          M1_ACK_O,
  output logic          M1_ERR_O,
  output logic          S_STB_O,
  output logic          S_WE_O,
  output logic [AW-1:0] S_ADR_O,
  output logic [DW-1:0] S_DAT_O,
  input  logic [DW-1:0] S_DAT_I,
  input  logic          S_ACK_I,
  output logic [1:0]    GNT_O
);
  arb_state_e state_q, state_d;
  logic last_q, last_d;
  logic [1:0] gnt_q;
  logic own0, own1, own_cyc, raw_stb, expire, g0, g1;
  assign own0 = state_q == GNT0;
  assign own1 = state_q == GNT1;
  assign own_cyc = (own0 & M0_CYC_I) | (own1 & M1_CYC_I);
  assign raw_stb = (own0 & M0_CYC_I & M0_STB_I) | (own1 & M1_CYC_I & M1_STB_I);
  assign S_STB_O = raw_stb & ~expire;
  assign S_WE_O = S_STB_O & (own0 ? M0_WE_I : M1_WE_I);
  assign S_ADR_O = own0 ? M0_ADR_I : own1 ? M1_ADR_I : '0;
  assign S_DAT_O = own0 ? M0_DAT_I : own1 ? M1_DAT_I : '0;
  assign M0_ACK_O = own0 & S_ACK_I & S_STB_O;
  assign M1_ACK_O = own1 & S_ACK_I & S_STB_O;
  assign M0_ERR_O = own0 & expire;
  assign M1_ERR_O = own1 & expire;
  assign M0_DAT_O = S_DAT_I;
  assign M1_DAT_O = S_DAT_I;
  assign GNT_O = gnt_q;
  // last_q = 1 means M1 was the most recent owner, so M0 wins a tie.
  assign g0 = M0_CYC_I & (~M1_CYC_I | last_q);
  assign g1 = M1_CYC_I & ~g0;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE) state_d = g0 ? GNT0 : g1 ? GNT1 : IDLE;
    else if (!own_cyc) begin
      last_d = own1;
      state_d = own0 ? (M1_CYC_I ? GNT1 : IDLE) : (M0_CYC_I ? GNT0 : IDLE);
    end
  end
  always_ff @(posedge CLK_I)
    if (RST_I) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      gnt_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_of(state_d);
    end
  // Releasing CYC (including the idle state) clears the count, so a grant change always starts fresh.
  wb_bram_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .CLR   (S_ACK_I | ~own_cyc),
    .RUN   (raw_stb),
    .EXPIRE(expire)
  );
endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb_wb_bram_arbiter: directed tests plus a cycle-by-cycle behavioural model of the arbiter and BRAM slave
module tb_wb_bram_arbiter;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [2:0] m0_adr = 0, m1_adr = 0;
  logic [31:0] m0_dat = 0, m1_dat = 0;
  logic [31:0] m0_rdat, m1_rdat, s_dat, s_rdat;
  logic m0_ack, m0_err, m1_ack, m1_err, s_stb, s_we, s_ack;
  logic [2:0] s_adr;
  logic [1:0] gnt;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  wb_bram_arbiter #(.AW(3), .DW(32), .TIMEOUT(TO)) dut (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat),
    .M0_DAT_O(m0_rdat), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
    .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat),
    .M1_DAT_O(m1_rdat), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
    .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADR_O(s_adr), .S_DAT_O(s_dat),
    .S_DAT_I(s_rdat), .S_ACK_I(s_ack), .GNT_O(gnt)
  );

  // BRAM slave: writes acknowledged in the strobe cycle, reads one cycle later; nack mutes all ACKs.
  logic [31:0] mem [8];
  logic rd_ack_q = 0, nack = 0;
  logic [31:0] rd_dat_q = 0;
  assign s_ack = ~nack & (rd_ack_q | (s_stb & s_we));
  assign s_rdat = rd_dat_q;
  always @(posedge clk) begin
    rd_ack_q <= s_stb & ~s_we & ~rd_ack_q;
    rd_dat_q <= mem[s_adr];
    if (s_stb & s_we) mem[s_adr] <= s_dat;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index, who went last, run length of unacknowledged strobes.
  int owner = -1, unacked = 0;
  bit last1 = 1, m_rd = 0, valid = 0;
  bit want, err, e_stb, e_we, e_sack;
  bit mc [2], ms [2], mw [2];
  logic [2:0] ma [2];
  logic [31:0] md [2];
  logic [31:0] ref_mem [8];
  always @(negedge clk) begin
    mc = '{m0_cyc, m1_cyc}; ms = '{m0_stb, m1_stb}; mw = '{m0_we, m1_we};
    ma = '{m0_adr, m1_adr}; md = '{m0_dat, m1_dat};
    want = owner >= 0 && mc[owner] && ms[owner];
    err = want && unacked == TO - 1;
    e_stb = want && !err;
    e_we = e_stb && mw[owner];
    e_sack = !nack && (m_rd || e_we);
    if (valid) begin
      chk("gnt", {30'd0, gnt}, owner < 0 ? 0 : 1 << owner);
      chk("s_stb", {31'd0, s_stb}, {31'd0, e_stb});
      chk("s_we", {31'd0, s_we}, {31'd0, e_we});
      chk("s_adr", {29'd0, s_adr}, owner < 0 ? 0 : {29'd0, ma[owner]});
      chk("s_dat", s_dat, owner < 0 ? 0 : md[owner]);
      chk("m0_ack", {31'd0, m0_ack}, {31'd0, owner == 0 && e_stb && e_sack});
      chk("m1_ack", {31'd0, m1_ack}, {31'd0, owner == 1 && e_stb && e_sack});
      chk("m0_err", {31'd0, m0_err}, {31'd0, owner == 0 && err});
      chk("m1_err", {31'd0, m1_err}, {31'd0, owner == 1 && err});
      if (owner >= 0 && e_stb && e_sack && !e_we)
        chk("rd_data", owner == 1 ? m1_rdat : m0_rdat, ref_mem[ma[owner]]);
    end
    if (e_stb && e_we) ref_mem[ma[owner]] = md[owner];
    m_rd = e_stb && !e_we && !m_rd;
    if (rst) begin
      owner = -1; last1 = 1; unacked = 0; valid = 1;
    end else if (owner < 0) begin
      owner = (mc[0] && mc[1]) ? (last1 ? 0 : 1) : mc[0] ? 0 : mc[1] ? 1 : -1;
      unacked = 0;
    end else if (!mc[owner]) begin
      last1 = owner == 1;
      owner = mc[1 - owner] ? 1 - owner : -1;
      unacked = 0;
    end else unacked = (err || e_sack) ? 0 : want ? unacked + 1 : unacked;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input bit c, input bit s, input bit w, input logic [2:0] a,
                       input logic [31:0] d);
    if (m == 0) begin m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat = d; end
    else begin m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat = d; end
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Single transfer from master m; lat = cycles from request to ACK.
  task automatic xfer(input int m, input bit w, input logic [2:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    bit got = 0;
    rd = 0;
    lat = -1;
    set_m(m, 1, 1, w, a, d);
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((m == 0 ? m0_ack : m1_ack) === 1'b1) begin
        got = 1; lat = i; rd = m == 0 ? m0_rdat : m1_rdat;
        chk("xfer_stb_with_ack", {31'd0, s_stb}, 1);
        break;
      end
      tick();
    end
    if (!got) chk("xfer_ack_seen", 0, 1);
    tick();
    set_m(m, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] rd;
  int lat, nseq;
  logic [1:0] seq [4];
  logic [1:0] prev;
  bit got0, got1;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + i;
    mem[1] = 32'h1111_1111; mem[2] = 32'h2222_2222; mem[3] = 32'hDEAD_BEEF; mem[5] = 32'h55AA_55AA;
    for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];
    do_reset();
    #1;
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_s_stb", {31'd0, s_stb}, 0);
    chk("rst_s_adr", {29'd0, s_adr}, 0);
    chk("rst_s_dat", s_dat, 0);
    chk("rst_errs", {30'd0, m0_err, m1_err}, 0);
    // 1: single read of BRAM[3]
    tick();
    set_m(0, 1, 1, 0, 3, 0);
    #1 chk("t1_c0_gnt", {30'd0, gnt}, 0);
    tick(); #1;
    chk("t1_c1_gnt", {30'd0, gnt}, 1);
    chk("t1_c1_stb", {31'd0, s_stb}, 1);
    chk("t1_c1_ack", {31'd0, m0_ack}, 0);
    tick(); #1;
    chk("t1_c2_ack", {31'd0, m0_ack}, 1);
    chk("t1_c2_data", m0_rdat, 32'hDEAD_BEEF);
    chk("t1_c2_m1_ack", {31'd0, m1_ack}, 0);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    tick();
    // 2: simultaneous request after reset, direct handover
    do_reset();
    set_m(0, 1, 1, 0, 3, 0);
    set_m(1, 1, 1, 0, 5, 0);
    tick(); #1;
    chk("t2_c1_gnt", {30'd0, gnt}, 1);
    chk("t2_c1_m1_ack", {31'd0, m1_ack}, 0);
    tick(); #1;
    chk("t2_c2_m0_ack", {31'd0, m0_ack}, 1);
    chk("t2_c2_m1_ack", {31'd0, m1_ack}, 0);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    #1 chk("t2_c3_gnt", {30'd0, gnt}, 1);
    tick(); #1;
    chk("t2_c4_gnt", {30'd0, gnt}, 2);
    chk("t2_c4_stb", {31'd0, s_stb}, 1);
    tick(); #1;
    chk("t2_c5_m1_ack", {31'd0, m1_ack}, 1);
    chk("t2_c5_m1_data", m1_rdat, 32'h55AA_55AA);
    tick();
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    // 3: both masters loop single reads; grants must alternate
    nseq = 0; prev = 0; got0 = 0; got1 = 0;
    for (int c = 0; c < 40 && nseq < 4; c++) begin
      set_m(0, !got0, !got0, 0, 1, 0);
      set_m(1, !got1, !got1, 0, 2, 0);
      #1;
      got0 = m0_ack; got1 = m1_ack;
      if (gnt != 0 && gnt != prev) begin seq[nseq] = gnt; nseq++; end
      prev = gnt;
      tick();
    end
    chk("t3_seq_len", nseq, 4);
    chk("t3_seq0", {30'd0, seq[0]}, 1);
    chk("t3_seq1", {30'd0, seq[1]}, 2);
    chk("t3_seq2", {30'd0, seq[2]}, 1);
    chk("t3_seq3", {30'd0, seq[3]}, 2);
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    // 4: M1 write, M0 read back
    xfer(1, 1, 7, 32'h1234_5678, rd, lat);
    chk("t4_wr_lat", lat, 1);
    xfer(0, 0, 7, 0, rd, lat);
    chk("t4_rd_data", rd, 32'h1234_5678);
    tick();
    // 5: slave never acknowledges
    nack = 1;
    set_m(0, 1, 1, 0, 2, 0);
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      chk("t5_gnt", {30'd0, gnt}, 1);
      chk("t5_err", {31'd0, m0_err}, {31'd0, c == 4});
      chk("t5_stb", {31'd0, s_stb}, {31'd0, c != 4});
      chk("t5_ack", {31'd0, m0_ack}, 0);
    end
    tick();
    m0_stb = 0;
    #1 chk("t5_c5_gnt", {30'd0, gnt}, 1);
    chk("t5_c5_err", {31'd0, m0_err}, 0);
    tick(); #1 chk("t5_c6_gnt", {30'd0, gnt}, 1);
    tick();
    m0_cyc = 0;
    tick(); #1 chk("t5_c8_gnt", {30'd0, gnt}, 0);
    nack = 0;
    tick();
    // 6: reset during an M1 read
    set_m(1, 1, 1, 0, 4, 0);
    tick(); #1;
    chk("t6_c1_gnt", {30'd0, gnt}, 2);
    chk("t6_c1_stb", {31'd0, s_stb}, 1);
    rst = 1;
    tick();
    rst = 0;
    set_m(0, 1, 1, 0, 3, 0);
    #1;
    chk("t6_c2_gnt", {30'd0, gnt}, 0);
    chk("t6_c2_stb", {31'd0, s_stb}, 0);
    chk("t6_c2_acks", {30'd0, m0_ack, m1_ack}, 0);
    tick(); #1 chk("t6_c3_gnt", {30'd0, gnt}, 1);
    tick(); #1;
    chk("t6_c4_ack", {31'd0, m0_ack}, 1);
    chk("t6_c4_data", m0_rdat, 32'hDEAD_BEEF);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
